// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue.
// The slave modport is the queue itself; the master modport is the
// fetch/decode side that drives entries in and consumes them.
interface fetch_queue_if #(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            flush_i;
    logic            enq_valid_i;
    logic            enq_ready_o;
    logic [XLEN-1:0] enq_pc_i;
    logic [ILEN-1:0] enq_instr_i;
    logic            deq_valid_o;
    logic            deq_ready_i;
    logic [XLEN-1:0] deq_pc_o;
    logic [ILEN-1:0] deq_instr_o;
    logic [CW-1:0]   count_o;

    modport slave (
        input  flush_i,
        input  enq_valid_i,
        input  enq_pc_i,
        input  enq_instr_i,
        input  deq_ready_i,
        output enq_ready_o,
        output deq_valid_o,
        output deq_pc_o,
        output deq_instr_o,
        output count_o
    );

    modport master (
        output flush_i,
        output enq_valid_i,
        output enq_pc_i,
        output enq_instr_i,
        output deq_ready_i,
        input  enq_ready_o,
        input  deq_valid_o,
        input  deq_pc_o,
        input  deq_instr_o,
        input  count_o
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular FIFO of {pc, instr} pairs between
// fetch and decode, with single-cycle synchronous flush and a NOP bubble
// presented to decode whenever nothing valid is at the head.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN -- when defined, an entry
// offered to an empty queue is forwarded combinationally to decode and,
// if consumed in the same cycle, never written into storage.
module fetch_queue #(
    parameter int              XLEN  = 64,
    parameter int              ILEN  = 32,
    parameter int              DEPTH = 4,
    parameter logic [ILEN-1:0] NOP   = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Pointers carry one extra MSB that toggles on every wrap.
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;

    // Storage is deliberately not reset; only pointers/count define validity.
    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [ILEN-1:0] instr_mem_q [DEPTH];

    logic [AW-1:0]   waddr;
    logic [AW-1:0]   raddr;
    logic            empty;
    logic            full;
    logic            bypass;
    logic            deq_valid;
    logic            enq_fire;
    logic            deq_fire;
    logic            wr_en;
    logic            rd_en;
    logic [XLEN-1:0] head_pc;
    logic [ILEN-1:0] head_instr;

    assign waddr = wptr_q[AW-1:0];
    assign raddr = rptr_q[AW-1:0];

    // Handshake decode, head selection and output muxing.
    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));
`ifdef FETCH_QUEUE_BYPASS_EN
        // An empty queue forwards whatever fetch offers this cycle.
        bypass = empty && !bus.flush_i;
`else
        bypass = 1'b0;
`endif
        if (bypass) begin
            deq_valid  = bus.enq_valid_i;
            head_pc    = bus.enq_pc_i;
            head_instr = bus.enq_instr_i;
        end else begin
            deq_valid  = !empty && !bus.flush_i;
            head_pc    = pc_mem_q[raddr];
            head_instr = instr_mem_q[raddr];
        end

        // Full blocks enqueue regardless of decode: no pass-through when full.
        enq_fire = bus.enq_valid_i && !full && !bus.flush_i;
        deq_fire = deq_valid && bus.deq_ready_i;

        // A bypassed entry consumed in the same cycle never touches storage.
        wr_en = enq_fire && !(bypass && deq_fire);
        rd_en = deq_fire && !bypass;

        bus.enq_ready_o = !full;
        bus.deq_valid_o = deq_valid;
        bus.deq_pc_o    = deq_valid ? head_pc : '0;
        bus.deq_instr_o = deq_valid ? head_instr : NOP;
        bus.count_o     = count_q;
    end

    // Next-state for pointers and occupancy; flush overrides all handshakes.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (bus.flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_en) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (rd_en) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/occupancy registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage write at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem_q[waddr]    <= bus.enq_pc_i;
            instr_mem_q[waddr] <= bus.enq_instr_i;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_fetch_queue;
    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP_C = 32'h0000_0013;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;
    ent_t mq[$];

    fetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // then advance the model across the edge. Entered/left after negedge.
    task automatic step(input bit ev, input logic [63:0] pc, input logic [31:0] ins,
                        input bit dr, input bit fl, output bit accepted);
        int   sz;
        bit   byp;
        bit   e_ready;
        bit   e_valid;
        bit   enq;
        bit   deq;
        ent_t head;
        ent_t ne;
        bus.enq_valid_i = ev;
        bus.enq_pc_i    = pc;
        bus.enq_instr_i = ins;
        bus.deq_ready_i = dr;
        bus.flush_i     = fl;
        #1;
        sz = mq.size();
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (sz == 0) && !fl;
`else
        byp = 1'b0;
`endif
        e_ready = (sz != DEPTH);
        e_valid = byp ? ev : ((sz != 0) && !fl);
        if (sz != 0) head = mq[0];
        else begin
            head.pc    = pc;
            head.instr = ins;
        end
        chk("count", 64'(bus.count_o), 64'(sz));
        chk("enq_ready", 64'(bus.enq_ready_o), 64'(e_ready));
        chk("deq_valid", 64'(bus.deq_valid_o), 64'(e_valid));
        chk("deq_pc", bus.deq_pc_o, e_valid ? head.pc : 64'h0);
        chk("deq_instr", 64'(bus.deq_instr_o), 64'(e_valid ? head.instr : NOP_C));
        @(posedge clk);
        enq = ev && e_ready && !fl;
        deq = e_valid && dr;
        accepted = enq;
        if (fl) begin
            mq.delete();
            $display("cyc %0d flush", cyc);
        end else begin
            if (deq) begin
                $display("cyc %0d deq pc=%h instr=%h", cyc, head.pc, head.instr);
                if (sz != 0) void'(mq.pop_front());
            end
            if (enq) begin
                $display("cyc %0d enq pc=%h instr=%h", cyc, pc, ins);
                if (!(byp && deq)) begin
                    ne.pc    = pc;
                    ne.instr = ins;
                    mq.push_back(ne);
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input bit dr);
        bit acc;
        step(1'b0, 64'h0, 32'h0, dr, 1'b0, acc);
    endtask

    initial begin
        bit          acc;
        int          sent;
        int          guard;
        bit          ev;
        bit          pend;
        logic [63:0] pc;
        logic [31:0] ins;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        bus.flush_i     = 1'b0;
        bus.enq_valid_i = 1'b0;
        bus.enq_pc_i    = '0;
        bus.enq_instr_i = '0;
        bus.deq_ready_i = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_count", 64'(bus.count_o), 64'd0);
        chk("rst_enq_ready", 64'(bus.enq_ready_o), 64'd1);
        chk("rst_deq_valid", 64'(bus.deq_valid_o), 64'd0);
        chk("rst_deq_pc", bus.deq_pc_o, 64'd0);
        chk("rst_deq_instr", 64'(bus.deq_instr_o), 64'(NOP_C));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill to DEPTH, hold a 5th entry, then drain in order
        for (int i = 0; i < 4; i++) step(1'b1, 64'h1000 + 64'(4 * i), $urandom, 1'b0, 1'b0, acc);
        step(1'b1, 64'h1010, 32'hDEAD_0005, 1'b0, 1'b0, acc);
        chk("fifth_rejected", 64'(acc), 64'd0);
        chk("full_count", 64'(bus.count_o), 64'd4);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);

        // Simultaneous enqueue and dequeue at count 2
        step(1'b1, 64'h3000, $urandom, 1'b0, 1'b0, acc);
        step(1'b1, 64'h3004, $urandom, 1'b0, 1'b0, acc);
        step(1'b1, 64'h3008, $urandom, 1'b1, 1'b0, acc);
        chk("simul_count", 64'(bus.count_o), 64'd2);
        chk("simul_head", bus.deq_pc_o, 64'h3004);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Wrap-around: 10 entries, decode ready toggling
        sent  = 0;
        guard = 0;
        while (sent < 10 && guard < 60) begin
            step(1'b1, 64'h4000 + 64'(4 * sent), $urandom, guard[0] == 1'b0, 1'b0, acc);
            if (acc) sent++;
            guard++;
            chk("wrap_max", 64'(bus.count_o <= 3'(DEPTH)), 64'd1);
        end
        chk("wrap_done", 64'(sent), 64'd10);
        for (int i = 0; i < 6; i++) idle(1'b1);

        // Flush with handshakes offered on both sides
        for (int i = 0; i < 3; i++) step(1'b1, 64'h5000 + 64'(4 * i), $urandom, 1'b0, 1'b0, acc);
        step(1'b1, 64'h500C, $urandom, 1'b1, 1'b1, acc);
        chk("flush_count", 64'(bus.count_o), 64'd0);
        idle(1'b1);

        // Empty queue: same-cycle bypass or one-cycle latency
        step(1'b1, 64'h2000, 32'h0000_2013, 1'b1, 1'b0, acc);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset with 3 entries queued
        for (int i = 0; i < 3; i++) step(1'b1, 64'h6000 + 64'(4 * i), $urandom, 1'b0, 1'b0, acc);
        bus.enq_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(bus.count_o), 64'd0);
        chk("arst_deq_valid", 64'(bus.deq_valid_o), 64'd0);
        chk("arst_deq_instr", 64'(bus.deq_instr_o), 64'h13);
        chk("arst_deq_pc", bus.deq_pc_o, 64'd0);
        chk("arst_enq_ready", 64'(bus.enq_ready_o), 64'd1);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);

        // Random traffic; fetch holds a refused entry stable
        pend = 1'b0;
        pc   = '0;
        ins  = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                ev  = ($urandom_range(0, 3) != 0);
                pc  = {$urandom, $urandom};
                ins = $urandom;
            end else begin
                ev = 1'b1;
            end
            step(ev, pc, ins, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, acc);
            pend = ev && !acc && (bus.count_o == 3'(DEPTH));
        end
        for (int i = 0; i < 6; i++) idle(1'b1);
        chk("final_empty", 64'(bus.count_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
